// File: rtl/i2c_pkg.sv
// Shared I2C timing constants and the byte-writer state encoding.
package i2c_pkg;

  localparam int HALF_PERIOD  = 500;  // 100 MHz reference -> 100 kHz SCL
  localparam int SAMPLE_POINT = 249;
  localparam int CNT_W        = 10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BIT_LOW  = 3'd1;
  localparam logic [2:0] ST_BIT_HIGH = 3'd2;
  localparam logic [2:0] ST_ACK_LOW  = 3'd3;
  localparam logic [2:0] ST_ACK_HIGH = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/i2c_phase_counter.sv
// SCL half-period counter; the enable doubles as the clock-stretch gate, so a
// held-low SCL freezes the count. Terminal and sample strobes are qualified by it.
module i2c_phase_counter #(
  parameter int HALF_PERIOD  = i2c_pkg::HALF_PERIOD,
  parameter int SAMPLE_POINT = i2c_pkg::SAMPLE_POINT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic terminal_o,
  output logic sample_o
);
  import i2c_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);

  logic [CNT_W-1:0] cnt_q;

  assign terminal_o = en_i && (cnt_q == LAST_CNT);
  assign sample_o   = en_i && (cnt_q == SAMPLE_CNT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i || terminal_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/protocol_write_byte.sv
// I2C byte writer: shifts one byte out MSB first, clocks the 9th (ACK) bit,
// then parks SCL low and pulses complete for one cycle.
module protocol_write_byte #(
  parameter int HALF_PERIOD  = i2c_pkg::HALF_PERIOD,
  parameter int SAMPLE_POINT = i2c_pkg::SAMPLE_POINT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       write_flag,
  input  logic [7:0] data_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_en,
  output logic       sda_en,
  output logic       busy,
  output logic       ack,
  output logic       complete
);
  import i2c_pkg::*;

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ack_q, ack_d;
  logic       scl_en_q, scl_en_d;
  logic       sda_en_q, sda_en_d;
  logic       busy_q, busy_d;
  logic       complete_q, complete_d;

  logic cnt_clear, cnt_en, cnt_terminal, cnt_sample;

  i2c_phase_counter #(
    .HALF_PERIOD  (HALF_PERIOD),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_phase_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (cnt_clear),
    .en_i       (cnt_en),
    .terminal_o (cnt_terminal),
    .sample_o   (cnt_sample)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ack_d     = ack_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (write_flag) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          ack_d     = 1'b0;
          state_d   = ST_BIT_LOW;
        end
      end
      ST_BIT_LOW: begin
        cnt_en = 1'b1;
        if (cnt_terminal) state_d = ST_BIT_HIGH;
      end
      ST_BIT_HIGH: begin
        cnt_en = scl_in;
        if (cnt_terminal) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_ACK_LOW;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = ST_BIT_LOW;
          end
        end
      end
      ST_ACK_LOW: begin
        cnt_en = 1'b1;
        if (cnt_terminal) state_d = ST_ACK_HIGH;
      end
      ST_ACK_HIGH: begin
        cnt_en = scl_in;
        if (cnt_sample) ack_d = ~sda_in;
        if (cnt_terminal) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_clear = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_q and carry no combinational path from any input.
  always_comb begin
    scl_en_d   = (state_d == ST_IDLE) || (state_d == ST_BIT_HIGH) ||
                 (state_d == ST_ACK_HIGH);
    sda_en_d   = ((state_d == ST_BIT_LOW) || (state_d == ST_BIT_HIGH)) ?
                 shift_d[7] : 1'b1;
    busy_d     = (state_d != ST_IDLE);
    complete_d = (state_d == ST_DONE);
  end

  // NOTE: the shift register is plain flops, not a memory, so it is reset
  // along with the rest of the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ack_q      <= 1'b0;
      scl_en_q   <= 1'b1;
      sda_en_q   <= 1'b1;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ack_q      <= ack_d;
      scl_en_q   <= scl_en_d;
      sda_en_q   <= sda_en_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
    end
  end

  assign scl_en   = scl_en_q;
  assign sda_en   = sda_en_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_protocol_write_byte.sv
// Directed bench for protocol_write_byte: models the I2C bus wires, a slave
// that can ACK, clock stretching, and records each transmitted byte.
module tb_protocol_write_byte;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_flag = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       scl_in, sda_in;
  logic       scl_en, sda_en, busy, ack, complete;

  logic stretch = 1'b0;
  logic ack_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  int         edge_cnt = 0;
  int         rise_cnt = 0;
  logic       scl_prev = 1'b1;
  logic [7:0] cap = 8'h00;
  bit         sda_low_seen = 1'b0;
  logic [7:0] got_bytes[$];
  int         comp_edges[$];

  assign scl_in = scl_en & ~stretch;
  assign sda_in = sda_en & ~(ack_mode & (((rise_cnt == 8) && !scl_en) || (rise_cnt == 9)));

  protocol_write_byte dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .write_flag (write_flag),
    .data_in    (data_in),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_en     (scl_en),
    .sda_en     (sda_en),
    .busy       (busy),
    .ack        (ack),
    .complete   (complete)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Bus monitor: SDA level at each SCL rising edge, byte capture on complete.
  always @(negedge clk) begin
    if (!reset_n) begin
      rise_cnt = 0;
      scl_prev = 1'b1;
    end else begin
      if (busy && scl_en && !scl_prev) begin
        rise_cnt = rise_cnt + 1;
        if (rise_cnt <= 8) cap = {cap[6:0], sda_in};
      end
      if (!sda_en) sda_low_seen = 1'b1;
      if (complete) begin
        got_bytes.push_back(cap);
        comp_edges.push_back(edge_cnt);
        rise_cnt = 0;
      end
      scl_prev = scl_en;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_byte(input logic [7:0] d, input bit hold, output int acc);
    write_flag = 1'b1;
    data_in    = d;
    tick();
    acc = edge_cnt;
    if (!hold) write_flag = 1'b0;
    if (busy !== 1'b1) begin
      $display("FAIL accept_busy: busy=%b expected 1", busy);
      errors++;
    end
    checks++;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if (got_bytes.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_to_rel(input int acc, input int rel);
    for (int i = 0; i < 20000 && (edge_cnt - acc + 1) < rel; i++) tick();
  endtask

  function automatic logic [7:0] byte_at(input int idx);
    return (got_bytes.size() > idx) ? got_bytes[idx] : 8'hxx;
  endfunction

  function automatic int rel_at(input int idx, input int acc);
    return (comp_edges.size() > idx) ? comp_edges[idx] - acc + 1 : -1;
  endfunction

  task automatic test_reset();
    tick();
    if ({scl_en, sda_en, busy, ack, complete} !== 5'b11000) begin
      $display("FAIL reset_outputs: scl_en,sda_en,busy,ack,complete=%b expected 11000",
               {scl_en, sda_en, busy, ack, complete});
      errors++;
    end
    checks++;
    reset_n = 1'b1;
    repeat (3) tick();
    if ({scl_en, sda_en, busy} !== 3'b110) begin
      $display("FAIL idle_outputs: scl_en,sda_en,busy=%b expected 110", {scl_en, sda_en, busy});
      errors++;
    end
    checks++;
  endtask

  task automatic test_byte_a5();
    int acc;
    bit ok;
    got_bytes.delete(); comp_edges.delete();
    ack_mode = 1'b1;
    start_byte(8'hA5, 1'b0, acc);
    wait_bytes(1, ok);
    if (!ok) begin
      $display("FAIL a5_timeout: no complete seen");
      errors++;
    end
    checks++;
    if ({complete, scl_en, sda_en, busy} !== 4'b1011) begin
      $display("FAIL a5_done_outputs: complete,scl_en,sda_en,busy=%b expected 1011",
               {complete, scl_en, sda_en, busy});
      errors++;
    end
    checks++;
    if (byte_at(0) !== 8'hA5) begin
      $display("FAIL a5_bus_bits: got %h expected a5", byte_at(0));
      errors++;
    end
    checks++;
    if (ack !== 1'b1) begin
      $display("FAIL a5_ack: got %b expected 1", ack);
      errors++;
    end
    checks++;
    if (rel_at(0, acc) !== 9001) begin
      $display("FAIL a5_latency: complete at cycle %0d expected 9001", rel_at(0, acc));
      errors++;
    end
    checks++;
    tick();
    if ({complete, busy, scl_en, ack} !== 4'b0011) begin
      $display("FAIL a5_after_done: complete,busy,scl_en,ack=%b expected 0011",
               {complete, busy, scl_en, ack});
      errors++;
    end
    checks++;
  endtask

  task automatic test_byte_ff_nack();
    int acc;
    bit ok;
    got_bytes.delete(); comp_edges.delete();
    ack_mode = 1'b0;
    sda_low_seen = 1'b0;
    start_byte(8'hFF, 1'b0, acc);
    wait_bytes(1, ok);
    if (!ok) begin
      $display("FAIL ff_timeout: no complete seen");
      errors++;
    end
    checks++;
    if (sda_low_seen !== 1'b0) begin
      $display("FAIL ff_sda_released: sda_en low seen=%b expected 0", sda_low_seen);
      errors++;
    end
    checks++;
    if (byte_at(0) !== 8'hFF) begin
      $display("FAIL ff_bus_bits: got %h expected ff", byte_at(0));
      errors++;
    end
    checks++;
    if (ack !== 1'b0) begin
      $display("FAIL ff_ack: got %b expected 0", ack);
      errors++;
    end
    checks++;
    if (rel_at(0, acc) !== 9001) begin
      $display("FAIL ff_latency: complete at cycle %0d expected 9001", rel_at(0, acc));
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_stretch();
    int acc;
    bit ok;
    got_bytes.delete(); comp_edges.delete();
    ack_mode = 1'b0;
    start_byte(8'h5A, 1'b0, acc);
    for (int i = 0; i < 20000 && rise_cnt < 4; i++) tick();
    stretch = 1'b1;
    repeat (200) tick();
    stretch = 1'b0;
    wait_bytes(1, ok);
    if (!ok) begin
      $display("FAIL stretch_timeout: no complete seen");
      errors++;
    end
    checks++;
    if (rel_at(0, acc) !== 9201) begin
      $display("FAIL stretch_latency: complete at cycle %0d expected 9201", rel_at(0, acc));
      errors++;
    end
    checks++;
    if (byte_at(0) !== 8'h5A) begin
      $display("FAIL stretch_bus_bits: got %h expected 5a", byte_at(0));
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_ignore_busy_write();
    int acc;
    bit ok;
    got_bytes.delete(); comp_edges.delete();
    ack_mode = 1'b1;
    start_byte(8'hC3, 1'b0, acc);
    run_to_rel(acc, 3000);
    write_flag = 1'b1;
    data_in    = 8'h00;
    tick();
    write_flag = 1'b0;
    wait_bytes(1, ok);
    if (!ok) begin
      $display("FAIL ignore_timeout: no complete seen");
      errors++;
    end
    checks++;
    if (byte_at(0) !== 8'hC3) begin
      $display("FAIL ignore_bus_bits: got %h expected c3", byte_at(0));
      errors++;
    end
    checks++;
    repeat (40) tick();
    if (got_bytes.size() !== 1 || busy !== 1'b0) begin
      $display("FAIL ignore_single_pulse: pulses=%0d busy=%b expected 1 and 0",
               got_bytes.size(), busy);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset_abort();
    int acc;
    bit ok;
    got_bytes.delete(); comp_edges.delete();
    ack_mode = 1'b1;
    start_byte(8'h96, 1'b0, acc);
    run_to_rel(acc, 4500);
    reset_n = 1'b0;
    #1;
    if ({scl_en, sda_en, busy, ack, complete} !== 5'b11000) begin
      $display("FAIL abort_outputs: scl_en,sda_en,busy,ack,complete=%b expected 11000",
               {scl_en, sda_en, busy, ack, complete});
      errors++;
    end
    checks++;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (50) tick();
    if (got_bytes.size() !== 0) begin
      $display("FAIL abort_no_complete: pulses=%0d expected 0", got_bytes.size());
      errors++;
    end
    checks++;
    start_byte(8'h3C, 1'b0, acc);
    wait_bytes(1, ok);
    if (!ok) begin
      $display("FAIL post_reset_timeout: no complete seen");
      errors++;
    end
    checks++;
    if (byte_at(0) !== 8'h3C || ack !== 1'b1) begin
      $display("FAIL post_reset_byte: got %h ack=%b expected 3c ack=1", byte_at(0), ack);
      errors++;
    end
    checks++;
    if (rel_at(0, acc) !== 9001) begin
      $display("FAIL post_reset_latency: complete at cycle %0d expected 9001", rel_at(0, acc));
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_back_to_back();
    int acc;
    bit ok;
    got_bytes.delete(); comp_edges.delete();
    ack_mode = 1'b1;
    start_byte(8'h12, 1'b1, acc);
    data_in = 8'h34;
    wait_bytes(2, ok);
    write_flag = 1'b0;
    if (!ok) begin
      $display("FAIL b2b_timeout: pulses=%0d expected 2", got_bytes.size());
      errors++;
    end
    checks++;
    if (byte_at(0) !== 8'h12 || byte_at(1) !== 8'h34) begin
      $display("FAIL b2b_bytes: got %h %h expected 12 34", byte_at(0), byte_at(1));
      errors++;
    end
    checks++;
    if (rel_at(0, acc) !== 9001) begin
      $display("FAIL b2b_first_latency: complete at cycle %0d expected 9001", rel_at(0, acc));
      errors++;
    end
    checks++;
    if (comp_edges.size() < 2 || (comp_edges[1] - comp_edges[0]) !== 9002) begin
      $display("FAIL b2b_spacing: spacing=%0d expected 9002",
               (comp_edges.size() < 2) ? -1 : comp_edges[1] - comp_edges[0]);
      errors++;
    end
    checks++;
    repeat (20) tick();
    if (got_bytes.size() !== 2 || busy !== 1'b0) begin
      $display("FAIL b2b_stop: pulses=%0d busy=%b expected 2 and 0", got_bytes.size(), busy);
      errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_byte_a5();
    test_byte_ff_nack();
    test_stretch();
    test_ignore_busy_write();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/protocol_write_byte.md
PROTOCOL_WRITE_BYTE -- requirements
Module: protocol_write_byte

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 500, meaning reference-clk cycles per SCL half period (100 MHz to 100 kHz).
REQ-002 SHALL have parameter SAMPLE_POINT, default 249, meaning the half-period counter value at which SDA is sampled during an SCL-high phase.
REQ-003 SHALL have port clk  input  1  FPGA reference clock, 100 MHz, single clock domain.
REQ-004 SHALL have port reset_n  input  1  user reset, asynchronous, active-low.
REQ-005 SHALL have port write_flag  input  1  request to transmit one byte; sampled only in IDLE.
REQ-006 SHALL have port data_in  input  8  byte to transmit, MSB first; latched on acceptance.
REQ-007 SHALL have port scl_in  input  1  synchronised SCL bus level, used for clock-stretch detection.
REQ-008 SHALL have port sda_in  input  1  synchronised SDA bus level, used for ACK sampling.
REQ-009 SHALL have port scl_en  output  1  0 drives SCL low, 1 releases it.
REQ-010 SHALL have port sda_en  output  1  0 drives SDA low, 1 releases it.
REQ-011 SHALL have port busy  output  1  high from acceptance until the DONE cycle inclusive.
REQ-012 SHALL have port ack  output  1  1 means the slave pulled SDA low in the 9th clock; valid from DONE until the next acceptance.
REQ-013 SHALL have port complete  output  1  single-cycle pulse marking end of byte plus ACK.

Function
REQ-014 SHALL implement states IDLE, BIT_LOW, BIT_HIGH, ACK_LOW, ACK_HIGH and DONE, with a 10-bit half-period counter and a 3-bit bit counter.
REQ-015 IDLE: scl_en=1, sda_en=1; on write_flag=1 at a clock edge, latch data_in into the shift register, clear both counters and go to BIT_LOW.
REQ-016 BIT_LOW: scl_en=0, sda_en=shift[7] (release for 1, drive for 0); counter runs 0..HALF_PERIOD-1, then clears and goes to BIT_HIGH.
REQ-017 BIT_HIGH: scl_en=1, sda_en unchanged; counter increments only while scl_in=1 (clock stretching holds it).
REQ-018 BIT_HIGH at counter=HALF_PERIOD-1 with bit_cnt<7: shift left by 1, increment bit_cnt and go to BIT_LOW.
REQ-019 BIT_HIGH at counter=HALF_PERIOD-1 with bit_cnt=7: go to ACK_LOW.
REQ-020 ACK_LOW: scl_en=0, sda_en=1; runs HALF_PERIOD cycles, then goes to ACK_HIGH.
REQ-021 ACK_HIGH: scl_en=1, sda_en=1; counter stretch-gated as in BIT_HIGH; at counter=SAMPLE_POINT register ack<=~sda_in; at HALF_PERIOD-1 go to DONE.
REQ-022 DONE: scl_en=0 (SCL left low for the next stage), sda_en=1, complete=1 for exactly one cycle, then go to IDLE.
REQ-023 With no stretching, complete SHALL be high in the cycle after edge 1+18*HALF_PERIOD (9001) counted from the accepting edge.
REQ-024 write_flag while busy=1 SHALL be ignored, and data_in changes after acceptance SHALL have no effect.
REQ-025 write_flag held high across DONE SHALL start a new byte on the first IDLE edge (back-to-back, one IDLE cycle gap).
REQ-026 A stretch of any length SHALL extend the high phase by exactly the number of cycles scl_in=0; no timeout.
REQ-027 scl_en, sda_en and complete SHALL be registered Moore outputs of the current state, with no combinational path from any input.

Reset
REQ-028 On reset_n=0, SHALL immediately go to IDLE with scl_en=1, sda_en=1, busy=0, ack=0, complete=0, and both counters and the shift register at 0.
REQ-029 Reset mid-byte SHALL abort with no complete pulse; the first post-reset write_flag starts a fresh byte from bit 7.

Structure
REQ-030 Shared package i2c_pkg SHALL hold HALF_PERIOD, SAMPLE_POINT and the state encoding; this block adds no other shared types.
REQ-031 One sub-module, i2c_phase_counter (HALF_PERIOD count with stretch-gate enable, terminal and sample strobes), SHALL be used; the remainder stays in this module.

Verification
REQ-032 data_in=0xA5, slave drives SDA low in ACK_HIGH, no stretch -> SDA levels 1,0,1,0,0,1,0,1 at each SCL rising edge; ack=1; complete at cycle 9001.
REQ-033 data_in=0xFF, SDA left released -> sda_en=1 throughout; ack=0; complete at cycle 9001.
REQ-034 scl_in held 0 for 200 cycles in the high phase of bit 3 -> complete at cycle 9201; bit values unchanged.
REQ-035 write_flag pulsed again at cycle 3000 with data_in=0x00 -> ignored; the byte on the bus is still the original value; one complete pulse.
REQ-036 reset_n=0 at cycle 4500 -> scl_en=sda_en=1 that cycle; no complete; a later write of 0x3C transmits correctly from bit 7.
REQ-037 write_flag held high with 0x12 then 0x34 -> two bytes with one IDLE cycle between; two complete pulses 9002 cycles apart.
